// File: rtl/my_computer_pkg.sv
// Shared opcodes, OUT port selects, segment constant and program ROM
// for the my_computer accumulator machine.
package my_computer_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_LD   = 4'h2,
      OP_ST   = 4'h3,
      OP_ADD  = 4'h4,
      OP_SUB  = 4'h5,
      OP_AND  = 4'h6,
      OP_OR   = 4'h7,
      OP_XOR  = 4'h8,
      OP_JMP  = 4'h9,
      OP_JZ   = 4'hA,
      OP_JC   = 4'hB,
      OP_ADDI = 4'hC,
      OP_IN   = 4'hD,
      OP_OUT  = 4'hE,
      OP_HALT = 4'hF
   } opcode_e;

   localparam logic [1:0] PORT_LED = 2'd0;
   localparam logic [1:0] PORT_P1  = 2'd1;
   localparam logic [1:0] PORT_P2  = 2'd2;
   localparam logic [1:0] PORT_P3  = 2'd3;

   localparam logic [6:0] SEG_ZERO = 7'h40;

   function automatic logic [15:0] rom_word(input logic [7:0] addr);
      logic [15:0] w;
      case (addr)
         8'h00:   w = 16'hD000;
         8'h01:   w = 16'hE000;
         8'h02:   w = 16'h1000;
         8'h03:   w = 16'hE001;
         8'h04:   w = 16'hC001;
         8'h05:   w = 16'h9003;
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/my_computer_hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7
   import my_computer_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_ZERO;
      unique case (i_hex)
         4'h0: o_seg = SEG_ZERO;
         4'h1: o_seg = 7'h79;
         4'h2: o_seg = 7'h24;
         4'h3: o_seg = 7'h30;
         4'h4: o_seg = 7'h19;
         4'h5: o_seg = 7'h12;
         4'h6: o_seg = 7'h02;
         4'h7: o_seg = 7'h78;
         4'h8: o_seg = 7'h00;
         4'h9: o_seg = 7'h10;
         4'hA: o_seg = 7'h08;
         4'hB: o_seg = 7'h03;
         4'hC: o_seg = 7'h46;
         4'hD: o_seg = 7'h21;
         4'hE: o_seg = 7'h06;
         4'hF: o_seg = 7'h0E;
      endcase
   end

endmodule

// File: rtl/my_computer.sv
// Single-cycle 8-bit accumulator computer, DE10-Lite board top.
// Define DEBUG_PC_DISPLAY_EN to show the live PC on HEX5:HEX4.
module my_computer
   import my_computer_pkg::*;
(
   input  logic       clk,
   output logic [9:0] LEDR,
   input  logic [9:0] SW,
   input  logic [3:0] KEY,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);

   logic [7:0] r_pc;
   logic [7:0] r_a;
   logic       r_z;
   logic       r_c;
   logic       r_halt;
   logic [7:0] r_led;
   logic [7:0] r_p1;
   logic [7:0] r_p2;
   logic [7:0] r_p3;
   logic [7:0] r_ram [16];

   logic        w_rst_n;
   logic        w_exec;
   logic [15:0] w_inst;
   opcode_e     w_op;
   logic [7:0]  w_k;
   logic [7:0]  w_mem;
   logic [8:0]  w_add9;
   logic [8:0]  w_addi9;
   logic [8:0]  w_sub9;
   logic        w_wr_a;
   logic [7:0]  w_res;
   logic        w_res_c;
   logic [7:0]  w_hi_disp;
   logic        w_unused;

   assign w_rst_n = KEY[0];
   assign w_exec  = SW[8] & ~r_halt;
   assign w_inst  = rom_word(r_pc);
   assign w_op    = opcode_e'(w_inst[15:12]);
   assign w_k     = w_inst[7:0];
   assign w_mem   = r_ram[w_k[3:0]];
   assign w_add9  = {1'b0, r_a} + {1'b0, w_mem};
   assign w_addi9 = {1'b0, r_a} + {1'b0, w_k};
   assign w_sub9  = {1'b0, r_a} - {1'b0, w_mem};

   // Everything that writes A also recomputes Z; C follows w_res_c.
   always_comb begin
      w_wr_a  = 1'b1;
      w_res   = r_a;
      w_res_c = r_c;
      unique case (w_op)
         OP_LDI:  w_res = w_k;
         OP_LD:   w_res = w_mem;
         OP_IN:   w_res = SW[7:0];
         OP_ADD:  {w_res_c, w_res} = w_add9;
         OP_ADDI: {w_res_c, w_res} = w_addi9;
         OP_SUB:  {w_res_c, w_res} = w_sub9;
         OP_AND:  {w_res_c, w_res} = {1'b0, r_a & w_mem};
         OP_OR:   {w_res_c, w_res} = {1'b0, r_a | w_mem};
         OP_XOR:  {w_res_c, w_res} = {1'b0, r_a ^ w_mem};
         default: w_wr_a = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_pc   <= '0;
         r_a    <= '0;
         r_z    <= 1'b0;
         r_c    <= 1'b0;
         r_halt <= 1'b0;
         r_led  <= '0;
         r_p1   <= '0;
         r_p2   <= '0;
         r_p3   <= '0;
      end else if (w_exec) begin
         r_pc <= r_pc + 8'd1;
         if (w_wr_a) begin
            r_a <= w_res;
            r_z <= (w_res == 8'd0);
            r_c <= w_res_c;
         end
         unique case (w_op)
            OP_JMP: r_pc <= w_k;
            OP_JZ:  if (r_z) r_pc <= w_k;
            OP_JC:  if (r_c) r_pc <= w_k;
            OP_HALT: begin
               r_halt <= 1'b1;
               r_pc   <= r_pc;
            end
            OP_OUT: begin
               unique case (w_k[1:0])
                  PORT_LED: r_led <= r_a;
                  PORT_P1:  r_p1  <= r_a;
                  PORT_P2:  r_p2  <= r_a;
                  PORT_P3:  r_p3  <= r_a;
               endcase
            end
            default: ;
         endcase
      end
   end

   // RAM is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (w_rst_n && w_exec && w_op == OP_ST)
         r_ram[w_k[3:0]] <= r_a;
   end

`ifdef DEBUG_PC_DISPLAY_EN
   assign w_hi_disp = r_pc;
`else
   assign w_hi_disp = r_p3;
`endif

   assign LEDR = {r_halt, r_z, r_led};

   hex_to_seg7 u_hex0 (.i_hex(r_p1[3:0]),      .o_seg(HEX0));
   hex_to_seg7 u_hex1 (.i_hex(r_p1[7:4]),      .o_seg(HEX1));
   hex_to_seg7 u_hex2 (.i_hex(r_p2[3:0]),      .o_seg(HEX2));
   hex_to_seg7 u_hex3 (.i_hex(r_p2[7:4]),      .o_seg(HEX3));
   hex_to_seg7 u_hex4 (.i_hex(w_hi_disp[3:0]), .o_seg(HEX4));
   hex_to_seg7 u_hex5 (.i_hex(w_hi_disp[7:4]), .o_seg(HEX5));

   assign w_unused = ^{KEY[3:1], SW[9], w_inst[11:8], r_p3};

endmodule

// File: tb/tb_my_computer.sv
// Self-checking bench for my_computer: ISA-level reference model,
// randomized switch data and pause patterns.
module tb_my_computer;

   logic       clk = 1'b0;
   logic [9:0] LEDR;
   logic [9:0] SW  = '0;
   logic [3:0] KEY = 4'b1110;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   int vec_cnt = 0;
   int err_cnt = 0;

   my_computer dut (
      .clk(clk), .LEDR(LEDR), .SW(SW), .KEY(KEY),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
      .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
   );

   always #5 clk = ~clk;

   logic [15:0] prog [256];
   logic [6:0]  seg  [16];

   logic [7:0] m_pc, m_a, m_led, m_p1, m_p2, m_p3;
   logic       m_z, m_c, m_halt;
   logic [7:0] m_ram [16];

   task automatic model_reset();
      m_pc = 0; m_a = 0; m_z = 0; m_c = 0; m_halt = 0;
      m_led = 0; m_p1 = 0; m_p2 = 0; m_p3 = 0;
   endtask

   // Architectural interpretation of one instruction.
   task automatic model_step();
      logic [15:0] w;
      logic [7:0]  k, mv;
      int          s;
      if (!(KEY[0] && SW[8] && !m_halt)) return;
      w  = prog[m_pc];
      k  = w[7:0];
      mv = m_ram[k[3:0]];
      m_pc = m_pc + 8'd1;
      case (w[15:12])
         4'h1: begin m_a = k; m_z = (m_a == 0); end
         4'h2: begin m_a = mv; m_z = (m_a == 0); end
         4'h3: m_ram[k[3:0]] = m_a;
         4'h4: begin
            s = int'(m_a) + int'(mv);
            m_c = (s > 255); m_a = 8'(s); m_z = (m_a == 0);
         end
         4'h5: begin
            m_c = (mv > m_a); m_a = m_a - mv; m_z = (m_a == 0);
         end
         4'h6: begin m_a = m_a & mv; m_c = 0; m_z = (m_a == 0); end
         4'h7: begin m_a = m_a | mv; m_c = 0; m_z = (m_a == 0); end
         4'h8: begin m_a = m_a ^ mv; m_c = 0; m_z = (m_a == 0); end
         4'h9: m_pc = k;
         4'hA: if (m_z) m_pc = k;
         4'hB: if (m_c) m_pc = k;
         4'hC: begin
            s = int'(m_a) + int'(k);
            m_c = (s > 255); m_a = 8'(s); m_z = (m_a == 0);
         end
         4'hD: begin m_a = SW[7:0]; m_z = (m_a == 0); end
         4'hE: case (k[1:0])
            2'd0: m_led = m_a;
            2'd1: m_p1 = m_a;
            2'd2: m_p2 = m_a;
            default: m_p3 = m_a;
         endcase
         4'hF: begin m_halt = 1; m_pc = m_pc - 8'd1; end
         default: ;
      endcase
   endtask

   function automatic logic [51:0] expv();
      logic [7:0] d;
`ifdef DEBUG_PC_DISPLAY_EN
      d = m_pc;
`else
      d = m_p3;
`endif
      return {m_halt, m_z, m_led,
              seg[d[7:4]], seg[d[3:0]],
              seg[m_p2[7:4]], seg[m_p2[3:0]],
              seg[m_p1[7:4]], seg[m_p1[3:0]]};
   endfunction

   function automatic logic [51:0] obsv();
      return {LEDR, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      KEY = 4'b1110;
      for (int i = 0; i < 3; i++) begin
         tick();
         model_reset();
         vec_cnt++;
         if (obsv() !== {10'h000, {6{7'h40}}}) begin
            err_cnt++;
            $display("FAIL reset_hold: got %h want %h", obsv(),
                     {10'h000, {6{7'h40}}});
         end
      end
   endtask

   task automatic test_echo();
      SW = {2'b01, 8'h5A};
      KEY = 4'b1111;
      tick(); tick();
      vec_cnt++;
      if (LEDR[7:0] !== 8'h5A || obsv() !== expv()) begin
         err_cnt++;
         $display("FAIL echo_edge2: got %h want %h", obsv(), expv());
      end
      tick();
      vec_cnt++;
      if (LEDR[8] !== 1'b1 || obsv() !== expv()) begin
         err_cnt++;
         $display("FAIL echo_z_edge3: got %h want %h", obsv(), expv());
      end
   endtask

   task automatic test_counter();
      logic [13:0] want;
      for (int e = 4; e <= 10; e++) begin
         SW[7:0] = 8'($urandom);
         tick();
         vec_cnt++;
         if (obsv() !== expv()) begin
            err_cnt++;
            $display("FAIL count_e%0d: got %h want %h", e, obsv(), expv());
         end
         if (e == 4 || e == 7 || e == 10) begin
            want = (e == 4) ? {7'h40, 7'h40} :
                   (e == 7) ? {7'h40, 7'h79} : {7'h40, 7'h24};
            vec_cnt++;
            if ({HEX1, HEX0} !== want) begin
               err_cnt++;
               $display("FAIL count_hex_e%0d: got %h want %h",
                        e, {HEX1, HEX0}, want);
            end
         end
      end
   endtask

   task automatic test_pause();
      logic [51:0] frozen;
      logic [7:0]  pc0, a0;
      frozen = obsv();
      pc0 = dut.r_pc;
      a0  = dut.r_a;
      SW[8] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         SW[7:0] = 8'($urandom);
         tick();
         vec_cnt++;
         if (obsv() !== frozen || dut.r_pc !== m_pc || dut.r_a !== m_a
             || m_pc !== pc0 || m_a !== a0) begin
            err_cnt++;
            $display("FAIL pause_%0d: got %h pc %h a %h want %h pc %h a %h",
                     i, obsv(), dut.r_pc, dut.r_a, expv(), m_pc, m_a);
         end
      end
      SW[8] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         vec_cnt++;
         if (obsv() !== expv()) begin
            err_cnt++;
            $display("FAIL resume_%0d: got %h want %h", i, obsv(), expv());
         end
      end
   endtask

   task automatic test_random_pause();
      for (int i = 0; i < 200; i++) begin
         SW = {1'b0, ($urandom_range(0, 3) != 0), 8'($urandom)};
         tick();
         vec_cnt++;
         if (obsv() !== expv() || dut.r_pc !== m_pc) begin
            err_cnt++;
            $display("FAIL rand_%0d: got %h pc %h want %h pc %h",
                     i, obsv(), dut.r_pc, expv(), m_pc);
         end
      end
      SW[8] = 1'b1;
   endtask

   task automatic test_wrap();
      int n = 0;
      while (!(m_a == 8'hFF && m_pc == 8'd4) && n < 3000) begin
         tick();
         n++;
         if (obsv() !== expv()) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL wrap_run_%0d: got %h want %h", n, obsv(), expv());
         end
      end
      vec_cnt++;
      if (n >= 3000) begin
         err_cnt++;
         $display("FAIL wrap_timeout: got a=%h want a=ff", m_a);
      end
      tick();
      vec_cnt++;
      if (dut.r_a !== 8'h00 || dut.r_c !== 1'b1 || LEDR[8] !== 1'b1
          || m_a !== 8'h00) begin
         err_cnt++;
         $display("FAIL wrap_flags: got a %h c %b z %b want a 00 c 1 z 1",
                  dut.r_a, dut.r_c, LEDR[8]);
      end
      tick(); tick();
      vec_cnt++;
      if ({HEX1, HEX0} !== {7'h40, 7'h40} || obsv() !== expv()) begin
         err_cnt++;
         $display("FAIL wrap_out: got %h want %h", obsv(), expv());
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      KEY[0] = 1'b0;
      #1;
      model_reset();
      vec_cnt++;
      if (obsv() !== {10'h000, {6{7'h40}}} || dut.r_pc !== 8'h00) begin
         err_cnt++;
         $display("FAIL async_reset: got %h pc %h want %h pc 00",
                  obsv(), dut.r_pc, {10'h000, {6{7'h40}}});
      end
      #2;
      KEY[0] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         SW[7:0] = 8'($urandom);
         tick();
         vec_cnt++;
         if (obsv() !== expv()) begin
            err_cnt++;
            $display("FAIL post_reset_%0d: got %h want %h",
                     i, obsv(), expv());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
      prog[0] = 16'hD000; prog[1] = 16'hE000; prog[2] = 16'h1000;
      prog[3] = 16'hE001; prog[4] = 16'hC001; prog[5] = 16'h9003;
      seg[0]  = 7'h40; seg[1]  = 7'h79; seg[2]  = 7'h24; seg[3]  = 7'h30;
      seg[4]  = 7'h19; seg[5]  = 7'h12; seg[6]  = 7'h02; seg[7]  = 7'h78;
      seg[8]  = 7'h00; seg[9]  = 7'h10; seg[10] = 7'h08; seg[11] = 7'h03;
      seg[12] = 7'h46; seg[13] = 7'h21; seg[14] = 7'h06; seg[15] = 7'h0E;
      for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
      model_reset();

      test_reset();
      test_echo();
      test_counter();
      test_pause();
      test_random_pause();
      test_wrap();
      test_async_reset();

      $display("== %0d vectors applied, %0d miscompares ==",
               vec_cnt, err_cnt);
      $finish;
   end

endmodule
